// File: rtl/cfg_register_bank.sv
// Parametrised slow-control register bank with per-register RO/RW and shadow attributes.
// Optional: define REG_AUTO_INC_EN to post-increment the register number after each access.
module cfg_register_bank #(
    parameter int                              NUM_REGS    = 64,
    parameter int                              DATA_WIDTH  = 32,
    parameter logic [NUM_REGS-1:0]             RW_MASK     = '1,
    parameter logic [NUM_REGS-1:0]             SHADOW_MASK = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  DEFAULTS    = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          rx_data,
    input  logic                           reg_num_le,
    input  logic                           wr_en,
    input  logic                           rd_en,
    output logic [DATA_WIDTH-1:0]          tx_data,
    output logic                           rd_valid,
    output logic                           illegal_reg_num,
    output logic                           wr_error,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_strobe,
    input  logic                           commit,
    input  logic                           acq_busy,
    output logic                           commit_pending,
    output logic                           commit_done,
    output logic [1:0]                     commit_state
);

    localparam int                     IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [NUM_REGS-1:0]    SHADOW_EFF   = SHADOW_MASK & RW_MASK;
    localparam logic [DATA_WIDTH:0]    NUM_REGS_EXT = (DATA_WIDTH+1)'(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0]  LAST_REG     = DATA_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } commit_state_e;

    commit_state_e state_q, state_d;
    logic          apply;

    logic [DATA_WIDTH-1:0]          reg_num_q, reg_num_d;
    logic [DATA_WIDTH-1:0]          tx_q, tx_d;
    logic                           rd_valid_q;
    logic                           wr_error_q;
    logic                           commit_done_q;
    logic [NUM_REGS-1:0]            wr_strobe_q, wr_strobe_d;

    logic                           illegal;
    logic [IDX_W-1:0]               sel;
    logic                           wr_legal;
    logic [NUM_REGS*DATA_WIDTH-1:0] active_flat;
    logic [NUM_REGS*DATA_WIDTH-1:0] rd_flat;
    logic [DATA_WIDTH-1:0]          rd_word;
    logic [DATA_WIDTH-1:0]          ro_word;

    assign illegal  = ({1'b0, reg_num_q} >= NUM_REGS_EXT);
    assign sel      = reg_num_q[IDX_W-1:0];
    assign wr_legal = wr_en && !illegal;

    // Per-register storage; read-only slots hold no flops and read back as 0 here,
    // the live ro_data value is substituted in the read mux.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [DATA_WIDTH-1:0] DEF = DEFAULTS[i*DATA_WIDTH +: DATA_WIDTH];
        logic hit;
        assign hit = wr_legal && (sel == IDX_W'(i));

        if (!RW_MASK[i]) begin : g_ro
            assign active_flat[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            assign rd_flat[i*DATA_WIDTH +: DATA_WIDTH]     = '0;
            assign wr_strobe_d[i]                          = 1'b0;
        end else if (SHADOW_EFF[i]) begin : g_shadow
            logic [DATA_WIDTH-1:0] shadow_q;
            logic [DATA_WIDTH-1:0] active_q;

            // In the APPLY cycle active takes the pre-write shadow; a concurrent
            // write lands in shadow only and waits for the next commit.
            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_q <= DEF;
                    active_q <= DEF;
                end else begin
                    if (hit) begin
                        shadow_q <= rx_data;
                    end
                    if (apply) begin
                        active_q <= shadow_q;
                    end
                end
            end

            assign active_flat[i*DATA_WIDTH +: DATA_WIDTH] = active_q;
            assign rd_flat[i*DATA_WIDTH +: DATA_WIDTH]     = shadow_q;
            assign wr_strobe_d[i]                          = apply;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] active_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    active_q <= DEF;
                end else if (hit) begin
                    active_q <= rx_data;
                end
            end

            assign active_flat[i*DATA_WIDTH +: DATA_WIDTH] = active_q;
            assign rd_flat[i*DATA_WIDTH +: DATA_WIDTH]     = active_q;
            assign wr_strobe_d[i]                          = hit;
        end
    end

    assign rd_word = rd_flat[sel*DATA_WIDTH +: DATA_WIDTH];
    assign ro_word = ro_data[sel*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        tx_d = tx_q;
        if (rd_en) begin
            if (illegal) begin
                tx_d = '0;
            end else if (!RW_MASK[sel]) begin
                tx_d = ro_word;
            end else begin
                tx_d = rd_word;
            end
        end
    end

    // A new number loaded in the same cycle as an access wins over the increment.
    always_comb begin
        reg_num_d = reg_num_q;
        if (reg_num_le) begin
            reg_num_d = rx_data;
        end
`ifdef REG_AUTO_INC_EN
        else if ((rd_en || wr_en) && !illegal) begin
            reg_num_d = (reg_num_q == LAST_REG) ? '0 : reg_num_q + DATA_WIDTH'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_num_q     <= '0;
            tx_q          <= '0;
            rd_valid_q    <= 1'b0;
            wr_error_q    <= 1'b0;
            wr_strobe_q   <= '0;
            commit_done_q <= 1'b0;
        end else begin
            reg_num_q     <= reg_num_d;
            tx_q          <= tx_d;
            rd_valid_q    <= rd_en;
            wr_error_q    <= wr_en && (illegal || !RW_MASK[sel]);
            wr_strobe_q   <= wr_strobe_d;
            commit_done_q <= apply;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PENDING is always visited, even when acq_busy is already low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (commit)    state_d = ST_PENDING;
            ST_PENDING: if (!acq_busy) state_d = ST_APPLY;
            ST_APPLY:                  state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        commit_pending = (state_q == ST_PENDING);
        apply          = (state_q == ST_APPLY);
    end

    assign commit_state    = state_q;
    assign tx_data         = tx_q;
    assign rd_valid        = rd_valid_q;
    assign illegal_reg_num = illegal;
    assign wr_error        = wr_error_q;
    assign reg_out         = active_flat;
    assign wr_strobe       = wr_strobe_q;
    assign commit_done     = commit_done_q;

endmodule
